// File: rtl/bcd_serial_addsub_pkg.sv
// Shared definitions for the serial BCD adder/subtractor: FSM encoding,
// seven-segment constants and the decimal glyph table.
package bcd_serial_addsub_pkg;

    // Controller states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    // Largest legal BCD digit
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Active-low segment patterns, segment order a..g from MSB to LSB
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b1111110;

    localparam logic [6:0] SEG_GLYPH [0:9] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001101,  // 7
        7'b0000000,  // 8
        7'b0000100   // 9
    };

endpackage

// File: rtl/bcd_serial_addsub_seg7.sv
// Single-digit BCD to active-low seven-segment decoder. Non-decimal codes
// (10-15) are shown blank so a corrupted digit never looks like a number.
module seg7_bcd_decoder
    import bcd_serial_addsub_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Look the digit up in the glyph table, blank when out of range
    always_comb begin
        o_seg = SEG_BLANK;
        for (int k = 0; k <= 9; k++) begin
            if (i_bcd == 4'(k)) begin
                o_seg = SEG_GLYPH[k];
            end
        end
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor, least significant digit first.
// Subtraction adds the nine's complement of B with an initial carry of one
// (ten's complement). If no carry leaves the top digit the difference is
// negative, and a second pass over the result (nine's complement plus one)
// turns it into a magnitude with a separate sign flag.
module bcd_serial_addsub
    import bcd_serial_addsub_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int CW     = 3
)
(
    input  logic                  i_clock,
    input  logic                  i_resetn,
    input  logic                  i_start,
    input  logic                  i_sub,
    input  logic [4*DIGITS-1:0]   i_a,
    input  logic [4*DIGITS-1:0]   i_b,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_s,
    output logic                  o_cout,
    output logic                  o_neg,
    output logic                  o_err,
    output logic [7*DIGITS-1:0]   o_hex,
    output logic [6:0]            o_hex_sign
);

    logic [1:0]            r_state;
    logic [4*DIGITS-1:0]   r_a;
    logic [4*DIGITS-1:0]   r_b;
    logic                  r_sub;
    logic [CW-1:0]         r_idx;
    logic                  r_carry;
    logic [4*DIGITS-1:0]   r_s;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_cout;
    logic                  r_neg;
    logic                  r_err;

    logic [3:0]            w_a_dig;
    logic [3:0]            w_b_dig;
    logic [3:0]            w_s_dig;
    logic [3:0]            w_op_x;
    logic [3:0]            w_op_y;
    logic [4:0]            w_sum;
    logic                  w_carry_out;
    logic [3:0]            w_dig_out;
    logic                  w_last;
    logic                  w_bad_in;

    function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > BCD_MAX) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    assign w_bad_in = has_bad_digit(i_a) | has_bad_digit(i_b);
    assign w_last   = (r_idx == CW'(DIGITS - 1));

    // Pick the current digit of each captured operand and of the result
    always_comb begin
        w_a_dig = '0;
        w_b_dig = '0;
        w_s_dig = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == CW'(i)) begin
                w_a_dig = r_a[4*i +: 4];
                w_b_dig = r_b[4*i +: 4];
                w_s_dig = r_s[4*i +: 4];
            end
        end
    end

    // Feed the shared digit adder: A/B in the main pass, complemented result in the fix pass
    always_comb begin
        if (r_state == ST_FIX) begin
            w_op_x = BCD_MAX - w_s_dig;
            w_op_y = 4'd0;
        end else begin
            w_op_x = w_a_dig;
            w_op_y = r_sub ? (BCD_MAX - w_b_dig) : w_b_dig;
        end
    end

    // One BCD digit adder shared by both passes
    assign w_sum       = {1'b0, w_op_x} + {1'b0, w_op_y} + {4'd0, r_carry};
    assign w_carry_out = (w_sum > {1'b0, BCD_MAX});
    assign w_dig_out   = w_carry_out ? 4'(w_sum - 5'd10) : w_sum[3:0];

    // Control FSM and result registers
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_s     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
            r_neg   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_a    <= i_a;
                        r_b    <= i_b;
                        r_sub  <= i_sub;
                        r_cout <= 1'b0;
                        r_neg  <= 1'b0;
                        if (w_bad_in) begin
                            r_err  <= 1'b1;
                            r_s    <= '0;
                            r_done <= 1'b1;
                        end else begin
                            r_err   <= 1'b0;
                            r_idx   <= '0;
                            r_carry <= i_sub;
                            r_busy  <= 1'b1;
                            r_state <= ST_ADD;
                        end
                    end
                end
                ST_ADD: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (r_idx == CW'(i)) begin
                            r_s[4*i +: 4] <= w_dig_out;
                        end
                    end
                    r_carry <= w_carry_out;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        if (!r_sub) begin
                            r_cout  <= w_carry_out;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else if (w_carry_out) begin
                            r_neg   <= 1'b0;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_neg   <= 1'b1;
                            r_idx   <= '0;
                            r_carry <= 1'b1;
                            r_state <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (r_idx == CW'(i)) begin
                            r_s[4*i +: 4] <= w_dig_out;
                        end
                    end
                    r_carry <= w_carry_out;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Display drivers for every result digit
    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dec
            seg7_bcd_decoder u_dec (
                .i_bcd (r_s[4*g +: 4]),
                .o_seg (o_hex[7*g +: 7])
            );
        end
    endgenerate

    assign o_hex_sign = r_neg ? SEG_MINUS : SEG_BLANK;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_s        = r_s;
    assign o_cout     = r_cout;
    assign o_neg      = r_neg;
    assign o_err      = r_err;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Scoreboard bench for bcd_serial_addsub: the driver pushes results predicted
// from decimal integer arithmetic; a monitor pops and compares on every done.
module tb_bcd_serial_addsub;

    localparam int DIGITS = 4;
    localparam int CW     = 3;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic                  sub;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   s;
    logic                  cout;
    logic                  neg;
    logic                  err;
    logic [7*DIGITS-1:0]   hex;
    logic [6:0]            hex_sign;

    bcd_serial_addsub #(.DIGITS(DIGITS), .CW(CW)) dut (
        .i_clock    (clk),
        .i_resetn   (rst_n),
        .i_start    (start),
        .i_sub      (sub),
        .i_a        (a),
        .i_b        (b),
        .o_busy     (busy),
        .o_done     (done),
        .o_s        (s),
        .o_cout     (cout),
        .o_neg      (neg),
        .o_err      (err),
        .o_hex      (hex),
        .o_hex_sign (hex_sign)
    );

    typedef struct {
        logic [4*DIGITS-1:0] s;
        logic                cout;
        logic                neg;
        logic                err;
        int                  lat;
        int                  done_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   busy_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, expv, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001101;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [7*DIGITS-1:0] hex_of(input logic [4*DIGITS-1:0] v);
        logic [7*DIGITS-1:0] h;
        for (int i = 0; i < DIGITS; i++) h[7*i +: 7] = glyph(int'(v[4*i +: 4]));
        return h;
    endfunction

    function automatic int bcd2int(input logic [4*DIGITS-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [4*DIGITS-1:0] int2bcd(input int n);
        logic [4*DIGITS-1:0] v;
        int x = n;
        for (int i = 0; i < DIGITS; i++) begin
            v[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return v;
    endfunction

    // Decimal reference: plain integer add/subtract modulo 10**DIGITS
    function automatic exp_t model(input logic [4*DIGITS-1:0] av, input logic [4*DIGITS-1:0] bv, input logic sb_sub);
        exp_t e;
        int   modv = 1;
        int   x, y, r;
        logic bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            modv = modv * 10;
            if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        e.s = '0; e.cout = 1'b0; e.neg = 1'b0; e.err = 1'b0; e.lat = 0; e.done_cyc = 0;
        if (bad) begin
            e.err = 1'b1;
        end else begin
            x = bcd2int(av);
            y = bcd2int(bv);
            if (!sb_sub) begin
                r = x + y;
                e.cout = (r >= modv);
                e.s = int2bcd(r % modv);
                e.lat = DIGITS;
            end else if (x >= y) begin
                e.s = int2bcd(x - y);
                e.lat = DIGITS;
            end else begin
                e.s = int2bcd(y - x);
                e.neg = 1'b1;
                e.lat = 2 * DIGITS;
            end
        end
        return e;
    endfunction

    // Monitor: compare each done pulse against the oldest prediction
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 64'(done), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("S", 64'(s), 64'(e.s));
                    chk("cout", 64'(cout), 64'(e.cout));
                    chk("neg", 64'(neg), 64'(e.neg));
                    chk("err", 64'(err), 64'(e.err));
                    chk("HEX", 64'(hex), 64'(hex_of(e.s)));
                    chk("HEX_SIGN", 64'(hex_sign), 64'(e.neg ? 7'b1111110 : 7'b1111111));
                    chk("latency", 64'(cyc), 64'(e.done_cyc));
                    chk("busy_cycles", 64'(busy_cnt), 64'(e.lat));
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic wait_empty();
        int k;
        for (k = 0; k < 60; k++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Issue one start pulse and predict its result
    task automatic issue(input logic [4*DIGITS-1:0] av, input logic [4*DIGITS-1:0] bv, input logic sv);
        exp_t e;
        @(negedge clk);
        a = av; b = bv; sub = sv; start = 1'b1;
        e = model(av, bv, sv);
        e.done_cyc = cyc + 1 + e.lat;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; sub = $urandom;
        chk("busy_after_start", 64'(busy), 64'(!e.err));
    endtask

    task automatic run_op(input logic [4*DIGITS-1:0] av, input logic [4*DIGITS-1:0] bv, input logic sv);
        issue(av, bv, sv);
        wait_empty();
    endtask

    function automatic logic [4*DIGITS-1:0] rand_bcd(input logic allow_bad);
        logic [4*DIGITS-1:0] v;
        for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        if (allow_bad && ($urandom_range(0, 7) == 0))
            v[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
        return v;
    endfunction

    initial begin
        exp_t e1, e2;
        int   c;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        #1;
        chk("rst_S", 64'(s), 64'(0));
        chk("rst_flags", 64'({busy, done, cout, neg, err}), 64'(0));
        chk("rst_HEX", 64'(hex), 64'(hex_of('0)));
        chk("rst_HEX_SIGN", 64'(hex_sign), 64'(7'b1111111));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op(16'h1234, 16'h5678, 1'b0);
        run_op(16'h9999, 16'h0001, 1'b0);
        run_op(16'h5000, 16'h1234, 1'b1);
        run_op(16'h1234, 16'h5000, 1'b1);
        run_op(16'h0042, 16'h0042, 1'b1);
        run_op(16'h12A4, 16'h0000, 1'b0);
        run_op(16'h0000, 16'h9999, 1'b1);
        run_op(16'h9999, 16'h9999, 1'b0);

        // Start pulse while busy is ignored
        issue(16'h1234, 16'h5000, 1'b1);
        @(negedge clk);
        a = 16'h9999; b = 16'h9999; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_empty();
        repeat (3) @(negedge clk);

        // Start held high: back-to-back operations
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; sub = 1'b0; start = 1'b1;
        c = cyc;
        e1 = model(16'h1234, 16'h5678, 1'b0);
        e1.done_cyc = c + 1 + e1.lat;
        e2 = e1;
        e2.done_cyc = e1.done_cyc + 1 + e2.lat;
        sb.push_back(e1);
        sb.push_back(e2);
        repeat (DIGITS + 2) @(negedge clk);
        start = 1'b0;
        wait_empty();

        // Asynchronous reset mid-operation
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_S", 64'(s), 64'(0));
        chk("abort_flags", 64'({busy, done, cout, neg, err}), 64'(0));
        chk("abort_HEX", 64'(hex), 64'(hex_of('0)));
        chk("abort_HEX_SIGN", 64'(hex_sign), 64'(7'b1111111));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        run_op(16'h0001, 16'h0001, 1'b0);

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            run_op(rand_bcd(1'b1), rand_bcd(1'b1), 1'($urandom_range(0, 1)));
        end

        repeat (10) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
